// File: rtl/selector_pkg.sv
// Shared constants and lookup function for the selector arbiter slice.
// Contents:
//   LUT_BASE, LUT_STEP : lookup is LUT_BASE + LUT_STEP * sel
//   SEL_W, DOUT_W      : selection and result widths
//   sel_to_val()       : selection code to result value
package selector_pkg;

  localparam int LUT_BASE = 10;
  localparam int LUT_STEP = 3;
  localparam int SEL_W    = 4;
  localparam int DOUT_W   = 7;

  // The top code (15) is defined to map to 55, which is exactly where the
  // linear formula lands, so one expression covers the whole range 10..55.
  function automatic logic [DOUT_W-1:0] sel_to_val(input logic [SEL_W-1:0] sel);
    return DOUT_W'(LUT_BASE + LUT_STEP * int'(sel));
  endfunction

endpackage

// File: rtl/selector_arb_if.sv
// Request/response bundle between requesting stages and the selector arbiter.
// Signals:
//   req_valid [NREQ]        per-requester valid
//   req_sel   [NREQ*SEL_W]  per-requester selection, requester i at [i*SEL_W +: SEL_W]
//   req_ready [NREQ]        one-hot grant
//   rsp_valid/rsp_id/rsp_data  registered response, rsp_ready from downstream
// Modports: slave = arbiter side, master = requester/consumer side.
interface selector_arb_if #(
  parameter int NREQ   = 4,
  parameter int SEL_W  = 4,
  parameter int DOUT_W = 7,
  parameter int ID_W   = $clog2(NREQ)
);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*SEL_W-1:0] req_sel;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic [ID_W-1:0]       rsp_id;
  logic [DOUT_W-1:0]     rsp_data;
  logic                  rsp_ready;

  modport slave (
    input  req_valid, req_sel, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport master (
    output req_valid, req_sel, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

endinterface

// File: rtl/selector_lut.sv
// Registered selection-to-value lookup, one cycle of latency.
// Ports:
//   clk, rst : clock, async active-high reset (dout -> 0)
//   en       : load sel_to_val(sel) on the next rising edge, else hold
//   sel      : selection code
//   dout     : registered lookup result
module selector_lut
  import selector_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [SEL_W-1:0]  sel,
  output logic [DOUT_W-1:0] dout
);

  logic [DOUT_W-1:0] dout_d, dout_q;

  always_comb begin
    dout_d = dout_q;
    if (en) dout_d = sel_to_val(sel);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dout_q <= '0;
    else     dout_q <= dout_d;
  end

  assign dout = dout_q;

endmodule

// File: rtl/selector_arb.sv
// Round-robin arbiter in front of a shared registered lookup.
// Ports:
//   clk, rst : clock, async active-high reset
//   bus      : selector_arb_if slave modport (requests in, tagged response out)
// A grant is issued only when the response slot is empty or draining this
// cycle; the granted selection is looked up and returned one cycle later.
module selector_arb
  import selector_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int ID_W = $clog2(NREQ)
) (
  input logic          clk,
  input logic          rst,
  selector_arb_if.slave bus
);

  logic [ID_W-1:0] ptr_d, ptr_q;
  logic            rsp_valid_d, rsp_valid_q;
  logic [ID_W-1:0] rsp_id_d, rsp_id_q;

  logic            can_issue;
  logic            any_valid;
  logic [ID_W-1:0] winner;
  logic            xfer;
  logic [SEL_W-1:0] win_sel;
  logic [DOUT_W-1:0] lut_dout;
  int              idx;

  assign can_issue = !rsp_valid_q || bus.rsp_ready;

  // Scan from the lowest priority slot back toward ptr so the last hit
  // written is the first valid requester at or after ptr.
  always_comb begin
    any_valid = 1'b0;
    winner    = '0;
    idx       = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (bus.req_valid[idx]) begin
        any_valid = 1'b1;
        winner    = ID_W'(idx);
      end
    end
  end

  assign xfer          = any_valid && can_issue;
  assign bus.req_ready = xfer ? (NREQ'(1) << winner) : '0;
  assign win_sel       = bus.req_sel[winner*SEL_W +: SEL_W];

  always_comb begin
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    if (xfer) begin
      ptr_d       = (winner == ID_W'(NREQ - 1)) ? '0 : winner + 1'b1;
      rsp_valid_d = 1'b1;
      rsp_id_d    = winner;
    end else if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  selector_lut u_lut (
    .clk  (clk),
    .rst  (rst),
    .en   (xfer),
    .sel  (win_sel),
    .dout (lut_dout)
  );

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = lut_dout;

endmodule

// File: tb/tb_selector_arb.sv
module tb_selector_arb;

  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  selector_arb_if #(.NREQ(NREQ)) bus ();
  selector_arb #(.NREQ(NREQ)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  int m_ptr  = 0;
  bit m_rv   = 0;
  int m_id   = 0;
  int m_data = 0;
  int gnt_log[$];
  int id0_seen = 0;

  function automatic int ref_val(input int s);
    return (s == 15) ? 55 : 10 + 3 * s;
  endfunction

  function automatic int ref_winner(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_rv = 0; m_id = 0; m_data = 0;
  endtask

  // One clock: check at the falling edge, advance model, return just after rising edge.
  task automatic step();
    int w;
    bit ci;
    logic [NREQ-1:0] exp_rdy;
    @(negedge clk);
    ci = !m_rv || bus.rsp_ready;
    w  = ref_winner(bus.req_valid, m_ptr);
    exp_rdy = (ci && w >= 0) ? NREQ'(1 << w) : '0;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_rv));
    chk("rsp_id",    32'(bus.rsp_id),    32'(m_id));
    chk("rsp_data",  32'(bus.rsp_data),  32'(m_data));
    if (bus.rsp_valid === 1'b1 && bus.rsp_id === '0) id0_seen++;
    if (ci && w >= 0) begin
      m_data = ref_val(int'(bus.req_sel[w*4 +: 4]));
      m_id   = w;
      m_rv   = 1;
      m_ptr  = (w + 1) % NREQ;
      gnt_log.push_back(w);
    end else if (m_rv && bus.rsp_ready) begin
      m_rv = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_sel(input int i, input int s);
    bus.req_sel[i*4 +: 4] = 4'(s);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_sel   = '0;
    bus.rsp_ready = 1'b1;
    #12 rst = 1'b0;
    @(posedge clk); #1;
    model_reset();
    step();

    // reset mid-response
    bus.req_valid = 4'b0100; set_sel(2, 7);
    step();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_id",    32'(bus.rsp_id),    32'd0);
    chk("rst_rsp_data",  32'(bus.rsp_data),  32'd0);
    model_reset();
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_sel(i, i);
    gnt_log.delete();
    step();
    chk("first_grant_after_rst", 32'(gnt_log[0]), 32'd0);

    // round-robin with all valid, sel = i
    for (int c = 0; c < 8; c++) step();
    for (int i = 0; i < 9; i++) chk("rr_order", 32'(gnt_log[i]), 32'(i % NREQ));

    // lookup sweep on requester 2
    bus.req_valid = 4'b0100;
    for (int s = 0; s < 16; s++) begin
      set_sel(2, s);
      step();
    end
    bus.req_valid = '0;
    step();
    step();

    // backpressure with id 1 / data 13 outstanding; requester 0 withdraws
    bus.req_valid = 4'b0010; set_sel(1, 1);
    step();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b1111;
    id0_seen = 0;
    step();
    bus.req_valid = 4'b1110;
    step();
    step();
    chk("bp_hold_id",   32'(bus.rsp_id),   32'd1);
    chk("bp_hold_data", 32'(bus.rsp_data), 32'd13);
    bus.rsp_ready = 1'b1;
    gnt_log.delete();
    step();
    chk("bp_resume_same_cycle", 32'(gnt_log.size()), 32'd1);
    for (int c = 0; c < 4; c++) step();
    bus.req_valid = '0;
    step();
    step();
    chk("withdrawn_id0_never_served", 32'(id0_seen), 32'd0);

    // sparse: ptr -> 2 via requester 1, then only 1 and 3 valid
    bus.req_valid = 4'b0010;
    step();
    bus.req_valid = 4'b1010;
    gnt_log.delete();
    for (int c = 0; c < 3; c++) step();
    chk("sparse_g0", 32'(gnt_log[0]), 32'd3);
    chk("sparse_g1", 32'(gnt_log[1]), 32'd1);
    chk("sparse_g2", 32'(gnt_log[2]), 32'd3);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      bus.req_valid = 4'($urandom_range(0, 15));
      bus.req_sel   = 16'($urandom);
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
